// File: rtl/ntcrack_pkg.sv
// Shared constants and state encoding for the NT-hash cracking pipeline.
package ntcrack_pkg;

  localparam int PW_MAX_CHARS = 20;
  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;
  localparam logic [7:0] MD4_PAD_BYTE = 8'h80;
  localparam int MD4_LEN_OFFSET = 56;
  localparam int MD4_BLOCK_BITS = 512;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } pad_state_e;

  function automatic logic char_ok(
    input logic [7:0] c
  );
    return (c >= CHAR_MIN) && (c <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/ntlm_md4_padder.sv
// Builds the MD4 block (UTF-16LE password, 0x80 pad, bit length) one char per cycle.
// Optional NTLM_MD4_PADDER_ERROR_EN adds length/char range checking and an error output.
module ntlm_md4_padder
  import ntcrack_pkg::*;
#(
  parameter int MAX_CHARS = PW_MAX_CHARS,
  parameter int LEN_W     = 5
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [8*MAX_CHARS-1:0]    in_password,
  input  logic [LEN_W-1:0]          in_length,
  input  logic                      trigger,
  output logic [MD4_BLOCK_BITS-1:0] out_block,
  output logic                      completed
`ifdef NTLM_MD4_PADDER_ERROR_EN
  ,
  output logic                      error
`endif
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_CHARS);

  pad_state_e state_q, state_d;
  logic [8*MAX_CHARS-1:0] pw_q, pw_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [MD4_BLOCK_BITS-1:0] blk_q, blk_d;
  logic done_q, done_d;
  logic trig_q;
  logic start;
  logic [LEN_W-1:0] len_lat;
  logic bad;
  logic err_q, err_d;

  assign start = trigger & ~trig_q;

`ifdef NTLM_MD4_PADDER_ERROR_EN
  assign len_lat = in_length;

  always_comb begin
    bad = (len_q > LEN_MAX);
    for (int i = 0; i < MAX_CHARS; i++) begin
      if ((LEN_W'(i) < len_q) && !char_ok(pw_q[8*i +: 8]))
        bad = 1'b1;
    end
  end

  assign error = err_q;
`else
  assign len_lat = (in_length > LEN_MAX) ? LEN_MAX : in_length;
  assign bad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    len_d   = len_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          pw_d    = in_password;
          len_d   = len_lat;
          idx_d   = '0;
          blk_d   = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        if (bad) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else if (idx_q < len_q) begin
          // UTF-16LE: char in even byte, zero high byte
          blk_d[{idx_q, 4'b0000} +: 8]     = pw_q[{idx_q, 3'b000} +: 8];
          blk_d[{idx_q, 4'b1000} +: 8]     = 8'h00;
          idx_d = idx_q + 1'b1;
        end else begin
          blk_d[{len_q, 4'b0000} +: 8]     = MD4_PAD_BYTE;
          blk_d[MD4_LEN_OFFSET*8 +: 64]    = 64'({len_q, 4'b0000});
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      pw_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
      err_q   <= err_d;
      trig_q  <= trigger;
    end
  end

  assign out_block = blk_q;
  assign completed = done_q;

endmodule

// File: tb/tb_ntlm_md4_padder.sv
// Randomized self-checking bench for ntlm_md4_padder.
// Reference model builds the block byte-by-byte from the padding rules.
module tb_ntlm_md4_padder;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         trigger = 1'b0;
  logic [159:0] pw = '0;
  logic [4:0]   len = '0;
  logic [511:0] blk;
  logic         completed;
`ifdef NTLM_MD4_PADDER_ERROR_EN
  logic         error;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ntlm_md4_padder dut (
    .clk         (clk),
    .nrst        (nrst),
    .in_password (pw),
    .in_length   (len),
    .trigger     (trigger),
    .out_block   (blk),
    .completed   (completed)
`ifdef NTLM_MD4_PADDER_ERROR_EN
    ,
    .error       (error)
`endif
  );

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_bad(logic [159:0] p, int l);
`ifdef NTLM_MD4_PADDER_ERROR_EN
    logic [7:0] c;
    if (l > 20) return 1'b1;
    for (int i = 0; i < l; i++) begin
      c = p[8*i +: 8];
      if (c < 8'h20 || c > 8'h7E) return 1'b1;
    end
    return 1'b0;
`else
    return (p == 160'h1) && (l < 0);
`endif
  endfunction

  function automatic logic [511:0] model_blk(logic [159:0] p, int l);
    logic [7:0] b [64];
    logic [511:0] r;
    int bits;
    r = '0;
    if (model_bad(p, l)) return r;
    if (l > 20) l = 20;
    for (int k = 0; k < 64; k++) b[k] = 8'h00;
    for (int i = 0; i < l; i++) b[2*i] = p[8*i +: 8];
    b[2*l] = 8'h80;
    bits = l * 16;
    b[56] = bits[7:0];
    b[57] = bits[15:8];
    for (int k = 0; k < 64; k++) r[8*k +: 8] = b[k];
    return r;
  endfunction

  function automatic int model_lat(logic [159:0] p, int l);
    if (model_bad(p, l)) return 1;
    return ((l > 20) ? 20 : l) + 1;
  endfunction

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic start_run(logic [159:0] p, logic [4:0] l, bit hold);
    @(negedge clk);
    pw = p;
    len = l;
    trigger = 1'b1;
    @(negedge clk);
    if (!hold) trigger = 1'b0;
    pw = rnd160();
    len = 5'($urandom());
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!completed && n < 40);
  endtask

  task automatic run_check(string tag, logic [159:0] p, logic [4:0] l, bit hold);
    int n;
    start_run(p, l, hold);
    chk({tag, "_busy"}, 512'(completed), 512'(0));
    wait_done(n);
    chk({tag, "_lat"}, 512'(n), 512'(model_lat(p, int'(l))));
    chk({tag, "_blk"}, blk, model_blk(p, int'(l)));
`ifdef NTLM_MD4_PADDER_ERROR_EN
    chk({tag, "_err"}, 512'(error), 512'(model_bad(p, int'(l))));
`endif
  endtask

  logic [159:0] p4, p7e, p;
  logic [511:0] blk20, snap;
  int l, n, drops;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    p4 = {16{8'h20}};
    p4 = {p4[127:0], 32'h54455354};
    p7e = {20{8'h7E}};

    repeat (3) @(negedge clk);
    chk("rst_blk", blk, '0);
    chk("rst_done", 512'(completed), 512'(0));
    nrst = 1'b1;
    @(negedge clk);

    run_check("len0", rnd160(), 5'd0, 1'b0);
    chk("len0_x0", 512'(blk[31:0]), 512'(32'h00000080));

    run_check("len4", p4, 5'd4, 1'b0);
    chk("len4_x0", 512'(blk[31:0]), 512'(32'h00530054));
    chk("len4_x1", 512'(blk[63:32]), 512'(32'h00540045));
    chk("len4_x2", 512'(blk[95:64]), 512'(32'h00000080));
    chk("len4_x14", 512'(blk[479:448]), 512'(32'h00000040));

    run_check("len20", p7e, 5'd20, 1'b0);
    chk("len20_x9", 512'(blk[319:288]), 512'(32'h007E007E));
    chk("len20_x10", 512'(blk[351:320]), 512'(32'h00000080));
    chk("len20_x14", 512'(blk[479:448]), 512'(32'h00000140));
    blk20 = blk;

    run_check("len21", p7e, 5'd21, 1'b0);
`ifndef NTLM_MD4_PADDER_ERROR_EN
    chk("len21_same", blk, blk20);
`endif

    start_run(p4, 5'd4, 1'b1);
    wait_done(n);
    chk("hold_lat", 512'(n), 512'(5));
    snap = blk;
    drops = 0;
    repeat (24) begin
      @(negedge clk);
      if (!completed) drops++;
      if (blk !== snap) drops++;
    end
    chk("hold_once", 512'(drops), 512'(0));
    trigger = 1'b0;
    @(negedge clk);
    run_check("redo", p4, 5'd4, 1'b0);

    start_run(p4, 5'd4, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    chk("midrst_blk", blk, '0);
    chk("midrst_done", 512'(completed), 512'(0));
    @(negedge clk);
    nrst = 1'b1;
    run_check("after_rst", p4, 5'd4, 1'b0);

    for (int it = 0; it < 40; it++) begin
`ifdef NTLM_MD4_PADDER_ERROR_EN
      l = $urandom_range(0, 23);
`else
      l = $urandom_range(0, 21);
`endif
      p = rnd160();
      for (int i = 0; i < 20; i++)
        if (i < l) p[8*i +: 8] = 8'($urandom_range(32, 126));
`ifdef NTLM_MD4_PADDER_ERROR_EN
      if (l > 0 && l <= 20 && $urandom_range(0, 3) == 0)
        p[8*$urandom_range(0, l - 1) +: 8] = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'($urandom_range(0, 31));
`endif
      run_check($sformatf("rnd%0d", it), p, 5'(l), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
